// File: rtl/cmd_sequencer_pkg.sv
// Shared command/state type and UART escape constants for the game front end.
package enum_type;

  // Command stream and game FSM state share one encoding; NONE means "nothing".
  typedef enum logic [3:0] {
    NONE, WAIT, LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV, BAR
  } state_type;

  localparam logic [7:0] ESC_BYTE = 8'h1B;
  localparam logic [7:0] CSI_BYTE = 8'h5B;

  typedef enum logic [1:0] {ESC_IDLE, ESC_ESC, ESC_CSI} esc_state_t;

  // Plain keystroke to command; unmapped bytes (incl. ESC/CSI) give NONE.
  function automatic state_type decode_key(input logic [7:0] b);
    case (b)
      8'h61, 8'h41:        return LEFT;
      8'h64, 8'h44:        return RIGHT;
      8'h73, 8'h53:        return DOWN;
      8'h77, 8'h57, 8'h20: return DROP;
      8'h63, 8'h43:        return HOLD;
      8'h78, 8'h58:        return ROTATE;
      8'h7A, 8'h5A:        return ROTATE_REV;
      8'h62, 8'h42:        return BAR;
      default:             return NONE;
    endcase
  endfunction

  // Final byte of an ESC-[ arrow sequence to command.
  function automatic state_type decode_csi(input logic [7:0] b);
    case (b)
      8'h41:   return ROTATE;
      8'h42:   return DOWN;
      8'h43:   return RIGHT;
      8'h44:   return LEFT;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_sequencer_fifo.sv
// Command FIFO: power-of-two depth, natural pointer wrap, combinational head.
module cmd_fifo
  import enum_type::*;
#(
  parameter int QSIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  state_type               din,
  output state_type               head,
  output logic [$clog2(QSIZE):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int PW = $clog2(QSIZE);

  state_type         mem [QSIZE];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       cnt;
  logic              do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(QSIZE));
  assign do_pop  = pop && !empty && !flush;
  // A pop frees the slot this cycle, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = empty ? NONE : mem[rd_ptr];
  assign count   = cnt;

  // Storage write; contents need no reset since cnt gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Game input front end: UART/ESC decode, switches, buttons with DAS/ARR,
// and level-scaled gravity merged into one prioritised command FIFO.
module cmd_sequencer
  import enum_type::*;
#(
  parameter int QSIZE     = 8,
  parameter int NBTN      = 4,
  parameter int DAS_DELAY = 10_000_000,
  parameter int ARR_TICK  = 2_000_000,
  parameter int GRAV_BASE = 50_000_000,
  parameter int LVL_W     = 4,
  parameter int LVL_MAX   = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   during,
  input  logic [NBTN-1:0]        btn,
  input  logic [3:0]             sw_toggle,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  input  logic [LVL_W-1:0]       level,
  input  state_type              state,
  output state_type              control,
  output logic [$clog2(QSIZE):0] count,
  output logic                   overflow
);
  localparam int DAS_MAX = (DAS_DELAY > ARR_TICK) ? DAS_DELAY : ARR_TICK;
  localparam int DW      = $clog2(DAS_MAX + 1);
  localparam int GW      = $clog2(GRAV_BASE + 1);

  logic [NBTN-1:0] btn_q, rise;
  logic            during_q, flush;
  esc_state_t      esc_q, esc_d;
  state_type       uart_cmd, sw_cmd, btn_cmd, rep_cmd, cand;
  logic            das_act, rep_fire, das_rise;
  logic [1:0]      das_idx;
  logic [DW-1:0]   das_cnt;
  logic [GW-1:0]   grav_cnt, period, grav_thr;
  logic            grav_pend, push, pop, full, empty;
  int              shamt;

  assign rise     = btn & ~btn_q;
  assign flush    = during_q && !during;
  assign das_rise = rise[0] | rise[1] | rise[3];

  // Edge/transition history; btn history runs through reset so a button
  // held across reset does not fake a press.
  always_ff @(posedge clk) begin
    btn_q <= btn;
    if (!reset_n) during_q <= 1'b0;
    else          during_q <= during;
  end

  // ESC FSM state register; parked in IDLE whenever the game is not running.
  always_ff @(posedge clk) begin
    if (!reset_n || !during) esc_q <= ESC_IDLE;
    else                     esc_q <= esc_d;
  end

  // ESC FSM next state and UART command decode.
  always_comb begin
    esc_d    = esc_q;
    uart_cmd = NONE;
    if (rx_valid) begin
      case (esc_q)
        ESC_IDLE: begin
          if (rx_byte == ESC_BYTE) esc_d = ESC_ESC;
          else                     uart_cmd = decode_key(rx_byte);
        end
        ESC_ESC: begin
          esc_d = ESC_IDLE;
          if (rx_byte == CSI_BYTE) esc_d = ESC_CSI;
          else                     uart_cmd = decode_key(rx_byte);
        end
        default: begin
          esc_d    = ESC_IDLE;
          uart_cmd = decode_csi(rx_byte);
        end
      endcase
    end
  end

  // Switch and button candidates, lowest index wins; plus repeat command.
  always_comb begin
    sw_cmd = NONE;
    if      (sw_toggle[0]) sw_cmd = DROP;
    else if (sw_toggle[1]) sw_cmd = HOLD;
    else if (sw_toggle[2]) sw_cmd = ROTATE_REV;
    else if (sw_toggle[3]) sw_cmd = BAR;
    btn_cmd = NONE;
    if      (rise[0]) btn_cmd = RIGHT;
    else if (rise[1]) btn_cmd = DOWN;
    else if (rise[2]) btn_cmd = ROTATE;
    else if (rise[3]) btn_cmd = LEFT;
    case (das_idx)
      2'd0:    rep_cmd = RIGHT;
      2'd1:    rep_cmd = DOWN;
      default: rep_cmd = LEFT;
    endcase
  end

  assign rep_fire = das_act && btn[das_idx] && (das_cnt == '0);

  // Single push candidate per cycle; idle mode turns any activity into WAIT.
  always_comb begin
    cand = NONE;
    if (!during) begin
      if (rx_valid || (|rise) || (|sw_toggle)) cand = WAIT;
    end else if (uart_cmd != NONE) cand = uart_cmd;
    else if (sw_cmd != NONE)       cand = sw_cmd;
    else if (btn_cmd != NONE)      cand = btn_cmd;
    else if (rep_fire)             cand = rep_cmd;
    else if (grav_pend)            cand = DOWN;
  end

  assign push = (cand != NONE);
  assign pop  = (state == WAIT) && !empty;

  // DAS/ARR: track the latest repeatable press, count down, reload on fire.
  always_ff @(posedge clk) begin
    if (!reset_n || !during) begin
      das_act <= 1'b0;
      das_idx <= 2'd0;
      das_cnt <= '0;
    end else if (das_rise) begin
      das_act <= 1'b1;
      das_idx <= rise[0] ? 2'd0 : (rise[1] ? 2'd1 : 2'd3);
      das_cnt <= DW'(DAS_DELAY - 1);
    end else if (das_act) begin
      if (!btn[das_idx]) begin
        das_act <= 1'b0;
        das_cnt <= '0;
      end else if (das_cnt == '0) begin
        das_cnt <= DW'(ARR_TICK - 1);
      end else begin
        das_cnt <= das_cnt - DW'(1);
      end
    end
  end

  // Gravity period from level; a zero period (deep levels) fires every cycle.
  always_comb begin
    shamt  = (int'(level) > LVL_MAX) ? LVL_MAX : int'(level);
    period = GW'(GRAV_BASE >> shamt);
    if (period == '0) period = GW'(1);
    grav_thr = period - GW'(1);
  end

  // Gravity timer: pushed DOWN restarts it; expiry sets pending and wins.
  always_ff @(posedge clk) begin
    if (!reset_n || !during) begin
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
    end else begin
      if (cand == DOWN) begin
        grav_cnt  <= '0;
        grav_pend <= 1'b0;
      end else begin
        grav_cnt <= grav_cnt + GW'(1);
      end
      if (grav_cnt >= grav_thr) begin
        grav_cnt  <= '0;
        grav_pend <= 1'b1;
      end
    end
  end

  // Sticky overflow: a push lost because the FIFO was full with no pop.
  always_ff @(posedge clk) begin
    if (!reset_n)                               overflow <= 1'b0;
    else if (push && full && !pop && !flush)    overflow <= 1'b1;
  end

  cmd_fifo #(.QSIZE(QSIZE)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (cand),
    .head    (control),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_cmd_sequencer.sv
// Randomised + directed bench for cmd_sequencer against a queue-based model.
module tb_cmd_sequencer;
  import enum_type::*;

  localparam int QSIZE = 4, NBTN = 4, DAS = 8, ARR = 3, GRAV = 64;
  localparam int LVL_W = 4, LVL_MAX = 10;

  logic            clk = 1'b0;
  logic            reset_n, during, rx_valid;
  logic [NBTN-1:0] btn;
  logic [3:0]      sw_toggle;
  logic [7:0]      rx_byte;
  logic [LVL_W-1:0] level;
  state_type       state, control;
  logic [2:0]      count;
  logic            overflow;

  always #5 clk = ~clk;

  cmd_sequencer #(
    .QSIZE(QSIZE), .NBTN(NBTN), .DAS_DELAY(DAS), .ARR_TICK(ARR),
    .GRAV_BASE(GRAV), .LVL_W(LVL_W), .LVL_MAX(LVL_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .during(during), .btn(btn),
    .sw_toggle(sw_toggle), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .level(level), .state(state), .control(control), .count(count),
    .overflow(overflow)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model ----
  state_type mq[$];
  bit        m_ovf, m_dur_q, m_das_act, m_gpend;
  logic [3:0] m_btn_q;
  int        m_esc, m_das_btn, m_das_cnt, m_gcnt;

  function automatic state_type key_cmd(input logic [7:0] b);
    case (b)
      "a", "A":      return LEFT;
      "d", "D":      return RIGHT;
      "s", "S":      return DOWN;
      "w", "W", " ": return DROP;
      "c", "C":      return HOLD;
      "x", "X":      return ROTATE;
      "z", "Z":      return ROTATE_REV;
      "b", "B":      return BAR;
      default:       return NONE;
    endcase
  endfunction

  function automatic state_type arrow_cmd(input logic [7:0] b);
    case (b)
      "A": return ROTATE;
      "B": return DOWN;
      "C": return RIGHT;
      "D": return LEFT;
      default: return NONE;
    endcase
  endfunction

  function automatic state_type btn_map(input int i);
    case (i)
      0: return RIGHT;
      1: return DOWN;
      2: return ROTATE;
      default: return LEFT;
    endcase
  endfunction

  function automatic state_type sw_map(input int i);
    case (i)
      0: return DROP;
      1: return HOLD;
      2: return ROTATE_REV;
      default: return BAR;
    endcase
  endfunction

  task automatic model_step();
    state_type cmd, u;
    logic [3:0] rise;
    bit pop, flush, rep;
    int period, sh, ncnt;
    bit npend;
    if (!reset_n) begin
      mq.delete(); m_ovf = 0; m_dur_q = 0; m_esc = 0;
      m_das_act = 0; m_das_cnt = 0; m_das_btn = 0; m_gcnt = 0; m_gpend = 0;
      m_btn_q = btn;
      return;
    end
    rise  = btn & ~m_btn_q;
    pop   = (state == WAIT) && (mq.size() > 0);
    flush = m_dur_q && !during;
    cmd   = NONE;
    if (!during) begin
      if (rx_valid || rise != 0 || sw_toggle != 0) cmd = WAIT;
      m_esc = 0; m_das_act = 0; m_das_cnt = 0; m_gcnt = 0; m_gpend = 0;
    end else begin
      u = NONE;
      if (rx_valid) begin
        if (m_esc == 2) begin u = arrow_cmd(rx_byte); m_esc = 0; end
        else if (m_esc == 1 && rx_byte == 8'h5B) m_esc = 2;
        else if (m_esc == 0 && rx_byte == 8'h1B) m_esc = 1;
        else begin m_esc = 0; u = key_cmd(rx_byte); end
      end
      rep = m_das_act && btn[m_das_btn] && m_das_cnt == 0;
      if (u != NONE) cmd = u;
      else if (sw_toggle != 0) begin
        for (int i = 3; i >= 0; i--) if (sw_toggle[i]) cmd = sw_map(i);
      end else if (rise != 0) begin
        for (int i = 3; i >= 0; i--) if (rise[i]) cmd = btn_map(i);
      end else if (rep) cmd = btn_map(m_das_btn);
      else if (m_gpend) cmd = DOWN;
      // auto-repeat tracking
      if (rise[0] || rise[1] || rise[3]) begin
        m_das_act = 1; m_das_cnt = DAS - 1;
        m_das_btn = rise[0] ? 0 : (rise[1] ? 1 : 3);
      end else if (m_das_act) begin
        if (!btn[m_das_btn]) m_das_act = 0;
        else if (m_das_cnt == 0) m_das_cnt = ARR - 1;
        else m_das_cnt--;
      end
      // gravity
      sh = (int'(level) > LVL_MAX) ? LVL_MAX : int'(level);
      period = GRAV >> sh;
      if (period < 1) period = 1;
      ncnt  = (cmd == DOWN) ? 0 : m_gcnt + 1;
      npend = (cmd == DOWN) ? 0 : m_gpend;
      if (m_gcnt >= period - 1) begin ncnt = 0; npend = 1; end
      m_gcnt = ncnt; m_gpend = npend;
    end
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (cmd != NONE) begin
        if (mq.size() < QSIZE) mq.push_back(cmd);
        else m_ovf = 1;
      end
    end
    m_dur_q = during;
    m_btn_q = btn;
  endtask

  // One clock: advance model, clock DUT, compare away from the edge.
  task automatic tick();
    state_type exp_ctrl;
    model_step();
    @(posedge clk);
    #1;
    exp_ctrl = (mq.size() > 0) ? mq[0] : NONE;
    chk("count", int'(count), mq.size());
    chk("control", int'(control), int'(exp_ctrl));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic rx(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
  endtask

  logic [7:0] pool [16] = '{8'h1B, 8'h5B, "a", "A", "d", "s", "w", " ",
                            "c", "x", "z", "b", "q", 8'h41, 8'h42, 8'h43};

  initial begin
    reset_n = 1'b0; during = 1'b0; btn = '0; sw_toggle = '0;
    rx_valid = 1'b0; rx_byte = '0; level = '0; state = NONE;
    #1;
    tick(); tick();
    chk("rst_count", int'(count), 0);
    chk("rst_control", int'(control), int'(NONE));
    chk("rst_overflow", int'(overflow), 0);

    // arrow sequence and ESC followed by a plain key
    reset_n = 1'b1; during = 1'b1;
    tick();
    rx(8'h1B); rx(8'h5B); rx(8'h44);
    chk("csi_count", int'(count), 1);
    chk("csi_left", int'(control), int'(LEFT));
    rx(8'h1B); rx("x");
    chk("esc_plain_count", int'(count), 2);

    // DAS/ARR on btn[0] with no pops, ending in overflow
    do_reset();
    btn = 4'b0001;
    tick();
    chk("das_edge_count", int'(count), 1);
    chk("das_edge_right", int'(control), int'(RIGHT));
    repeat (7) tick();
    chk("das_before", int'(count), 1);
    tick();
    chk("das_first", int'(count), 2);
    repeat (11) tick();
    chk("das_full", int'(count), 4);
    chk("das_ovf", int'(overflow), 1);
    btn = '0; tick();

    // gravity at level 2, then the deep-level clamp
    do_reset();
    level = 4'd2; state = WAIT;
    repeat (60) tick();
    level = 4'd15;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("grav_max_count", int'(count), 1);
      chk("grav_max_down", int'(control), int'(DOWN));
    end

    // same-cycle UART, switch and button: UART wins alone
    level = '0; state = NONE;
    do_reset();
    tick();
    rx_valid = 1'b1; rx_byte = "a"; sw_toggle = 4'b0001; btn = 4'b1000;
    tick();
    rx_valid = 1'b0; sw_toggle = '0; btn = '0;
    chk("prio_count", int'(count), 1);
    chk("prio_left", int'(control), int'(LEFT));
    tick(); tick();
    chk("prio_after", int'(count), 1);

    // full FIFO with simultaneous pop and push
    do_reset();
    rx("a"); rx("d"); rx("s"); rx("w");
    chk("fill_count", int'(count), 4);
    state = WAIT;
    rx("c");
    state = NONE;
    chk("fullpp_count", int'(count), 4);
    chk("fullpp_head", int'(control), int'(RIGHT));
    chk("fullpp_ovf", int'(overflow), 0);

    // idle mode WAIT pushes, flush on during fall, then reset mid-queue
    during = 1'b0;
    tick();
    chk("flush_count", int'(count), 0);
    rx("q");
    chk("idle_count", int'(count), 1);
    chk("idle_wait", int'(control), int'(WAIT));
    rx("q");
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("midq_count", int'(count), 0);
    chk("midq_control", int'(control), int'(NONE));

    // randomised traffic
    during = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NBTN; b++) if ($urandom_range(15) == 0) btn[b] = ~btn[b];
      sw_toggle = ($urandom_range(15) == 0) ? 4'($urandom) : 4'd0;
      rx_valid  = ($urandom_range(3) == 0);
      rx_byte   = pool[$urandom_range(15)];
      state     = ($urandom_range(2) == 0) ? WAIT : NONE;
      if ($urandom_range(99) == 0) level = 4'($urandom);
      if ($urandom_range(199) == 0) during = ~during;
      reset_n   = ($urandom_range(499) != 0);
      tick();
    end
    rx_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
